// File: rtl/divx_if.sv
// divx_if: operand/result handshake bundle for the divx fixed-point divider.
// Latency: none (wiring only).
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
// Ports: in_valid, in_ready, a, b, sgn, rnd, tag_in (operation in);
//        out_valid, out_ready, val, dbz, ovf, tag_out (result out).
// slave = the divider, master = producer/consumer side.
interface divx_if #(
  parameter int WIDTH = 16,
  parameter int TAGW  = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sgn;
  logic             rnd;
  logic [TAGW-1:0]  tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] val;
  logic             dbz;
  logic             ovf;
  logic [TAGW-1:0]  tag_out;

  modport slave (
    input  in_valid, a, b, sgn, rnd, tag_in, out_ready,
    output in_ready, out_valid, val, dbz, ovf, tag_out
  );

  modport master (
    output in_valid, a, b, sgn, rnd, tag_in, out_ready,
    input  in_ready, out_valid, val, dbz, ovf, tag_out
  );
endinterface

// File: rtl/divx.sv
// divx: signed/unsigned fixed-point divider, truncate or round-half-away, one op at a time.
// Latency: WIDTH+FBITS+1 cycles (truncate), WIDTH+FBITS+2 (round), 1 cycle on divide by zero.
// Backpressure: in_ready only in IDLE; result held stable in OUT until out_ready.
// Ports: clk, rst_n (async active-low); io (divx_if.slave) carries operands, mode, tag and result.
module divx #(
  parameter int WIDTH = 16,
  parameter int FBITS = 8,
  parameter int TAGW  = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  divx_if.slave io
);
  localparam int NW = WIDTH + FBITS;    // dividend bits: |a| scaled by 2^FBITS
  localparam int QW = NW + 2;           // quotient register, never saturates
  localparam int CW = $clog2(NW + 2);   // iteration counter

  typedef enum logic [1:0] {IDLE, CALC, FIN, OUT} state_t;

  state_t           state;
  logic [NW-1:0]    dvd;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] bmag;
  logic [QW-1:0]    q;
  logic [CW-1:0]    cnt;
  logic             sgn_r, rnd_r, neg_r, dbz_r;
  logic [TAGW-1:0]  tag_r;

  logic             out_valid_r;
  logic [WIDTH-1:0] val_r;
  logic             dbz_o, ovf_o;
  logic [TAGW-1:0]  tag_o;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH+1:0] trial, rem_nxt;
  logic             q_bit;
  logic [CW-1:0]    k_last;
  logic [QW-1:0]    m, lim;
  logic [WIDTH-1:0] m_lo, res;
  logic             ovf_c;
  logic             unused_bit;

  assign io.in_ready  = (state == IDLE);
  assign io.out_valid = out_valid_r;
  assign io.val       = val_r;
  assign io.dbz       = dbz_o;
  assign io.ovf       = ovf_o;
  assign io.tag_out   = tag_o;

  always_comb begin
    // Magnitude of the most-negative value wraps to 2^(WIDTH-1), which is correct unsigned.
    a_mag   = (io.sgn && io.a[WIDTH-1]) ? -io.a : io.a;
    b_mag   = (io.sgn && io.b[WIDTH-1]) ? -io.b : io.b;
    // Restoring step: bring in the next dividend bit, subtract divisor if it fits.
    trial   = {acc, dvd[NW-1]};
    q_bit   = (trial >= (WIDTH+2)'(bmag));
    rem_nxt = q_bit ? (trial - (WIDTH+2)'(bmag)) : trial;
    // Rounding runs one extra iteration to produce a guard bit.
    k_last  = rnd_r ? CW'(NW) : CW'(NW - 1);
    // Rounding on the magnitude gives half-away-from-zero for both signs.
    m       = rnd_r ? ((q + QW'(1)) >> 1) : q;
    if (!sgn_r)     lim = QW'({WIDTH{1'b1}});
    else if (neg_r) lim = QW'(1) << (WIDTH - 1);
    else            lim = (QW'(1) << (WIDTH - 1)) - QW'(1);
    ovf_c   = (m > lim);
    m_lo    = m[WIDTH-1:0];
    res     = neg_r ? -m_lo : m_lo;
  end

  // Remainder never exceeds WIDTH+1 bits; the top trial bit is only for the compare.
  assign unused_bit = rem_nxt[WIDTH+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      dvd         <= '0;
      acc         <= '0;
      bmag        <= '0;
      q           <= '0;
      cnt         <= '0;
      sgn_r       <= 1'b0;
      rnd_r       <= 1'b0;
      neg_r       <= 1'b0;
      dbz_r       <= 1'b0;
      tag_r       <= '0;
      out_valid_r <= 1'b0;
      val_r       <= '0;
      dbz_o       <= 1'b0;
      ovf_o       <= 1'b0;
      tag_o       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (io.in_valid) begin
            sgn_r <= io.sgn;
            rnd_r <= io.rnd;
            tag_r <= io.tag_in;
            neg_r <= io.sgn & (io.a[WIDTH-1] ^ io.b[WIDTH-1]);
            bmag  <= b_mag;
            dvd   <= NW'(a_mag) << FBITS;
            acc   <= '0;
            q     <= '0;
            cnt   <= '0;
            dbz_r <= (io.b == '0);
            state <= (io.b == '0) ? FIN : CALC;
          end
        end
        CALC: begin
          acc <= rem_nxt[WIDTH:0];
          dvd <= dvd << 1;
          q   <= {q[QW-2:0], q_bit};
          cnt <= cnt + CW'(1);
          if (cnt == k_last) state <= FIN;
        end
        FIN: begin
          out_valid_r <= 1'b1;
          tag_o       <= tag_r;
          dbz_o       <= dbz_r;
          ovf_o       <= !dbz_r && ovf_c;
          val_r       <= (dbz_r || ovf_c) ? '0 : res;
          state       <= OUT;
        end
        OUT: begin
          if (io.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_divx.sv
// tb_divx: self-checking bench for divx in Q4.4 (WIDTH=8, FBITS=4).
// Latency: n/a. Backpressure: exercised by holding out_ready low.
// Directed cases plus randomized operations against an arithmetic reference model.
module tb_divx;
  localparam int W = 8;
  localparam int F = 4;
  localparam int T = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  divx_if #(.WIDTH(W), .TAGW(T)) bus ();

  divx #(.WIDTH(W), .FBITS(F), .TAGW(T)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  // Reference: exact integer division of the real-valued operands, then mode rules.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic s, input logic r,
                                output logic [W-1:0] v, output logic d, output logic o);
    int ai, bi, am, bm, num, qq, rem, lim;
    logic neg;
    v = '0; d = 1'b0; o = 1'b0;
    if (b == '0) begin
      d = 1'b1;
      return;
    end
    ai  = s ? int'($signed(a)) : int'(a);
    bi  = s ? int'($signed(b)) : int'(b);
    am  = (ai < 0) ? -ai : ai;
    bm  = (bi < 0) ? -bi : bi;
    neg = s && ((ai < 0) != (bi < 0));
    num = am * (1 << F);
    qq  = num / bm;
    rem = num % bm;
    if (r && (2 * rem >= bm)) qq++;
    lim = !s ? (1 << W) - 1 : (neg ? (1 << (W - 1)) : (1 << (W - 1)) - 1);
    if (qq > lim) o = 1'b1;
    else v = W'(neg ? -qq : qq);
  endfunction

  // Drives one operation, waits for its result, then accepts it. Starts and ends on a negedge.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic r, input logic [T-1:0] tg,
                       output logic [W-1:0] v, output logic d, output logic o,
                       output logic [T-1:0] tgo, output int lat, output logic tmo);
    int guard;
    tmo = 1'b0;
    lat = 0;
    guard = 0;
    @(negedge clk);
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) tmo = 1'b1;
    bus.a = a; bus.b = b; bus.sgn = s; bus.rnd = r; bus.tag_in = tg;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!bus.out_valid) tmo = 1'b1;
    v = bus.val; d = bus.dbz; o = bus.ovf; tgo = bus.tag_out;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_chk++;
    if ({bus.out_valid, bus.val, bus.dbz, bus.ovf, bus.tag_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0",
               {bus.out_valid, bus.val, bus.dbz, bus.ovf, bus.tag_out});
    end
    n_chk++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL post_reset_ready_valid: got %b want 10", {bus.in_ready, bus.out_valid});
    end
  endtask

  task automatic test_unsigned_latency();
    logic [W-1:0] v; logic d, o, tmo; logic [T-1:0] tg; int lat;
    for (int r = 0; r < 2; r++) begin
      do_op(8'h30, 8'h20, 1'b0, r[0], 4'h1, v, d, o, tg, lat, tmo);
      n_chk++;
      if ({tmo, v, d, o} !== {1'b0, 8'h18, 2'b00}) begin
        n_fail++;
        $display("FAIL unsigned_val rnd=%0d: got tmo=%b val=%h dbz=%b ovf=%b want val=18 flags 0",
                 r, tmo, v, d, o);
      end
      n_chk++;
      if (lat !== 13 + r) begin
        n_fail++;
        $display("FAIL unsigned_latency rnd=%0d: got %0d want %0d", r, lat, 13 + r);
      end
    end
  endtask

  task automatic test_signed_round();
    logic [W-1:0] ta [5], tb [5], te [5];
    logic         tr [5];
    logic [W-1:0] v; logic d, o, tmo; logic [T-1:0] tg; int lat;
    ta = '{8'h20, 8'h20, 8'hE0, 8'hE0, 8'hD0};
    tb = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h20};
    tr = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    te = '{8'h0A, 8'h0B, 8'hF6, 8'hF5, 8'hE8};
    for (int i = 0; i < 5; i++) begin
      do_op(ta[i], tb[i], 1'b1, tr[i], T'(i), v, d, o, tg, lat, tmo);
      n_chk++;
      if ({tmo, v, d, o, tg} !== {1'b0, te[i], 2'b00, T'(i)}) begin
        n_fail++;
        $display("FAIL signed_round[%0d]: got tmo=%b val=%h dbz=%b ovf=%b tag=%h want val=%h tag=%h",
                 i, tmo, v, d, o, tg, te[i], T'(i));
      end
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] ta [4], tb [4], te [4];
    logic         ts [4], to [4];
    logic [W-1:0] v; logic d, o, tmo; logic [T-1:0] tg; int lat;
    ta = '{8'hF0, 8'h80, 8'h80, 8'h7F};
    tb = '{8'h08, 8'h10, 8'hF0, 8'h10};
    ts = '{1'b0, 1'b1, 1'b1, 1'b1};
    to = '{1'b1, 1'b0, 1'b1, 1'b0};
    te = '{8'h00, 8'h80, 8'h00, 8'h7F};
    for (int i = 0; i < 4; i++) begin
      do_op(ta[i], tb[i], ts[i], 1'b0, 4'h2, v, d, o, tg, lat, tmo);
      n_chk++;
      if ({tmo, v, d, o} !== {1'b0, te[i], 1'b0, to[i]}) begin
        n_fail++;
        $display("FAIL overflow[%0d]: got tmo=%b val=%h dbz=%b ovf=%b want val=%h ovf=%b",
                 i, tmo, v, d, o, te[i], to[i]);
      end
    end
  endtask

  task automatic test_dbz();
    logic [W-1:0] v; logic d, o, tmo; logic [T-1:0] tg; int lat;
    do_op(8'h55, 8'h00, 1'b0, 1'b0, 4'hC, v, d, o, tg, lat, tmo);
    n_chk++;
    if ({tmo, v, d, o, tg, lat} !== {1'b0, 8'h00, 2'b10, 4'hC, 32'd1}) begin
      n_fail++;
      $display("FAIL dbz_unsigned: got tmo=%b val=%h dbz=%b ovf=%b tag=%h lat=%0d want 0/1/0/c/1",
               tmo, v, d, o, tg, lat);
    end
    do_op(8'h80, 8'h00, 1'b1, 1'b1, 4'hD, v, d, o, tg, lat, tmo);
    n_chk++;
    if ({tmo, v, d, o, tg, lat} !== {1'b0, 8'h00, 2'b10, 4'hD, 32'd1}) begin
      n_fail++;
      $display("FAIL dbz_signed: got tmo=%b val=%h dbz=%b ovf=%b tag=%h lat=%0d want 0/1/0/d/1",
               tmo, v, d, o, tg, lat);
    end
    do_op(8'h30, 8'h20, 1'b0, 1'b0, 4'hE, v, d, o, tg, lat, tmo);
    n_chk++;
    if ({tmo, v, d, o, lat} !== {1'b0, 8'h18, 2'b00, 32'd13}) begin
      n_fail++;
      $display("FAIL after_dbz: got tmo=%b val=%h dbz=%b ovf=%b lat=%0d want 18/0/0/13",
               tmo, v, d, o, lat);
    end
  endtask

  task automatic test_backpressure();
    int guard, extra;
    @(negedge clk);
    bus.a = 8'h20; bus.b = 8'h30; bus.sgn = 1'b1; bus.rnd = 1'b1; bus.tag_in = 4'h9;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    guard = 0;
    while (!bus.out_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    n_chk++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_result_timeout: out_valid=%b after %0d cycles want 1", bus.out_valid, guard);
    end
    // A competing operation is offered while the result is blocked; it must be ignored.
    bus.a = 8'h11; bus.b = 8'h01; bus.sgn = 1'b0; bus.rnd = 1'b0; bus.tag_in = 4'h6;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_chk++;
      if ({bus.out_valid, bus.in_ready, bus.val, bus.dbz, bus.ovf, bus.tag_out} !==
          {2'b10, 8'h0B, 2'b00, 4'h9}) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got valid=%b ready=%b val=%h dbz=%b ovf=%b tag=%h want 1/0/0b/0/0/9",
                 i, bus.out_valid, bus.in_ready, bus.val, bus.dbz, bus.ovf, bus.tag_out);
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_chk++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL bp_release: got valid=%b ready=%b want 0/1", bus.out_valid, bus.in_ready);
    end
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_valid) extra++;
    end
    n_chk++;
    if (extra !== 0) begin
      n_fail++;
      $display("FAIL bp_phantom_result: got %0d valid cycles want 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int             acc_cyc[$];
    logic [T-1:0]   tags[$];
    logic [W-1:0]   vals[$];
    logic           pend;
    @(negedge clk);
    bus.a = 8'h30; bus.b = 8'h20; bus.sgn = 1'b0; bus.rnd = 1'b0; bus.tag_in = 4'h3;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    pend = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (pend) begin
        acc_cyc.push_back(c - 1);
        if (acc_cyc.size() == 1) begin
          bus.a = 8'hE0; bus.b = 8'h30; bus.sgn = 1'b1; bus.rnd = 1'b1; bus.tag_in = 4'h5;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      pend = bus.in_valid && bus.in_ready;
      if (bus.out_valid) begin
        tags.push_back(bus.tag_out);
        vals.push_back(bus.val);
      end
      if (tags.size() == 2) break;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_chk++;
    if (tags.size() !== 2 || acc_cyc.size() !== 2) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d results %0d accepts want 2 and 2", tags.size(), acc_cyc.size());
    end else begin
      n_chk++;
      if ({tags[0], vals[0], tags[1], vals[1]} !== {4'h3, 8'h18, 4'h5, 8'hF5}) begin
        n_fail++;
        $display("FAIL b2b_order: got %h/%h then %h/%h want 3/18 then 5/f5",
                 tags[0], vals[0], tags[1], vals[1]);
      end
      n_chk++;
      if (acc_cyc[1] - acc_cyc[0] !== 15) begin
        n_fail++;
        $display("FAIL b2b_accept_gap: got %0d want 15", acc_cyc[1] - acc_cyc[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] v; logic d, o, tmo; logic [T-1:0] tg; int lat, extra, guard;
    // Reset while the quotient is being computed.
    @(negedge clk);
    bus.a = 8'h30; bus.b = 8'h20; bus.sgn = 1'b0; bus.rnd = 1'b0; bus.tag_in = 4'h7;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({bus.in_ready, bus.out_valid, bus.val, bus.dbz, bus.ovf, bus.tag_out} !== {1'b1, 15'd0}) begin
      n_fail++;
      $display("FAIL reset_calc: got ready=%b valid=%b val=%h want ready 1, rest 0",
               bus.in_ready, bus.out_valid, bus.val);
    end
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.out_valid) extra++;
    end
    n_chk++;
    if (extra !== 0) begin
      n_fail++;
      $display("FAIL reset_stale_valid: got %0d valid cycles want 0", extra);
    end
    // Reset while a result is being presented.
    bus.a = 8'h20; bus.b = 8'h30; bus.sgn = 1'b1; bus.rnd = 1'b1; bus.tag_in = 4'hA;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    guard = 0;
    while (!bus.out_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    n_chk++;
    if ({bus.out_valid, bus.val, bus.tag_out} !== {1'b1, 8'h0B, 4'hA}) begin
      n_fail++;
      $display("FAIL reset_out_setup: got valid=%b val=%h tag=%h want 1/0b/a",
               bus.out_valid, bus.val, bus.tag_out);
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({bus.in_ready, bus.out_valid, bus.val, bus.dbz, bus.ovf, bus.tag_out} !== {1'b1, 15'd0}) begin
      n_fail++;
      $display("FAIL reset_out: got ready=%b valid=%b val=%h dbz=%b ovf=%b tag=%h want ready 1, rest 0",
               bus.in_ready, bus.out_valid, bus.val, bus.dbz, bus.ovf, bus.tag_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_op(8'hD0, 8'h20, 1'b1, 1'b0, 4'hB, v, d, o, tg, lat, tmo);
    n_chk++;
    if ({tmo, v, d, o, tg, lat} !== {1'b0, 8'hE8, 2'b00, 4'hB, 32'd13}) begin
      n_fail++;
      $display("FAIL reset_next_op: got tmo=%b val=%h dbz=%b ovf=%b tag=%h lat=%0d want e8/0/0/b/13",
               tmo, v, d, o, tg, lat);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, v, ev; logic s, r, d, o, ed, eo, tmo; logic [T-1:0] tg, tgi; int lat, elat;
    for (int i = 0; i < 40; i++) begin
      a   = W'($urandom);
      b   = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      s   = 1'($urandom);
      r   = 1'($urandom);
      tgi = T'($urandom);
      model(a, b, s, r, ev, ed, eo);
      elat = (b == '0) ? 1 : W + F + 1 + int'(r);
      do_op(a, b, s, r, tgi, v, d, o, tg, lat, tmo);
      n_chk++;
      if ({tmo, v, d, o, tg} !== {1'b0, ev, ed, eo, tgi} || lat !== elat) begin
        n_fail++;
        $display("FAIL random[%0d] a=%h b=%h sgn=%b rnd=%b: got val=%h dbz=%b ovf=%b tag=%h lat=%0d tmo=%b want val=%h dbz=%b ovf=%b tag=%h lat=%0d",
                 i, a, b, s, r, v, d, o, tg, lat, tmo, ev, ed, eo, tgi, elat);
      end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sgn       = 1'b0;
    bus.rnd       = 1'b0;
    bus.tag_in    = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_unsigned_latency();
    test_signed_round();
    test_overflow();
    test_dbz();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/divx.md
# divx

Parametrised fixed-point divider, the successor to the single-mode unsigned divider. It adds a per-operation selection of signed or unsigned operands and a per-operation choice between truncation and round-half-away-from-zero. Operands enter and results leave through valid/ready handshakes, and a user tag travels with each operation. It sits between fixed-point producers (for example ray-step and projection math) and consumers that may apply backpressure, and it processes one operation at a time.

## Interface
Parameters:
- WIDTH, 16: operand and result width in bits, integer plus fractional (two's complement when signed).
- FBITS, 8: fractional bits within WIDTH; 0 ≤ FBITS < WIDTH.
- TAGW, 4: width of the user tag passed through with each operation; ≥ 1.

Ports (clock and reset first):
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands and mode are presented.
- in_ready  out  1  block accepts an operation; equals (state == IDLE).
- a  in  WIDTH  dividend.
- b  in  WIDTH  divisor.
- sgn  in  1  1 = operands and result are signed two's complement; 0 = unsigned.
- rnd  in  1  1 = round half away from zero; 0 = truncate toward zero.
- tag_in  in  TAGW  user tag.
- out_valid  out  1  result is presented.
- out_ready  in  1  consumer accepts the result.
- val  out  WIDTH  quotient; 0 when dbz or ovf is set.
- dbz  out  1  divide by zero.
- ovf  out  1  result not representable.
- tag_out  out  TAGW  tag of the result being presented.

## Operation
States and transitions:
- IDLE → CALC on accept (in_valid && in_ready), with b ≠ 0.
- IDLE → FIN on accept with b == 0.
- CALC → FIN after K iterations.
- FIN → OUT.
- OUT → IDLE on out_ready.

Accept (latched in the same edge):
- Latch sgn, rnd, tag_in, neg = sgn & (a[MSB] ^ b[MSB]), and magnitudes |a|, |b|.
- Magnitudes are WIDTH bits unsigned; the magnitude of the most-negative value is 2^(WIDTH-1).

CALC:
- Restoring shift/subtract of |a|·2^FBITS by |b|, one quotient bit per cycle, MSB first.
- K = WIDTH+FBITS+rnd iterations; when rnd = 1 the extra iteration is a guard bit.
- Quotient register is WIDTH+FBITS+2 bits and never saturates.
- Accumulator is WIDTH+1 bits.

FIN:
- Rounding: m = rnd ? (q+1)>>1 : q. Rounding is applied to the magnitude, which gives half-away-from-zero.
- Overflow limit by mode:
  - unsigned: ovf if m > 2^WIDTH−1;
  - signed, neg = 1: ovf if m > 2^(WIDTH-1);
  - signed, neg = 0: ovf if m > 2^(WIDTH-1)−1.
- Result: val = neg ? −m : m, taking the low WIDTH bits, and only when no flag is set.
- Flags: dbz = 1 when b == 0; then ovf = 0 and val = 0. When ovf = 1, val = 0.
- No early-exit on overflow. Latency is fixed per mode.

OUT:
- val, dbz, ovf and tag_out are held stable until out_ready.
- Inputs are ignored while in_ready = 0.

Reset:
- rst_n low at any time forces IDLE.
- out_valid, val, dbz, ovf and tag_out are set to 0.
- Any in-flight operation is discarded and no result is emitted for it.
- in_ready reads 1 during and after reset.

## Timing
- Accept edge = edge 0.
- out_valid rises after edge K+1; b == 0 gives out_valid after edge 1.
- Latency from the accept edge to the first out_valid cycle:
  - WIDTH+FBITS+1 cycles with truncation;
  - WIDTH+FBITS+2 cycles with rounding;
  - 1 cycle for divide by zero.
- The result transfers on the edge where out_valid && out_ready. out_valid falls and in_ready rises after that edge.
- No accept in the same cycle as result transfer. The minimum gap between accepts is K+3 cycles.
- out_ready high while out_valid is low has no effect.
- in_valid may be held high continuously; each accept consumes exactly one operation.

## Test plan
Tests 1–4 use WIDTH=8, FBITS=4 (Q4.4).
1. Unsigned and latency: a=0x30, b=0x20, sgn=0, rnd=0 → val=0x18 (1.5), flags 0, out_valid 13 cycles after accept. Same with rnd=1 → 14 cycles.
2. Signed and rounding:
   - a=0x20, b=0x30, sgn=1: rnd=0 → 0x0A; rnd=1 → 0x0B.
   - a=0xE0, b=0x30: rnd=0 → 0xF6; rnd=1 → 0xF5.
   - a=0xD0, b=0x20 → 0xE8.
3. Overflow boundaries:
   - unsigned a=0xF0, b=0x08 → ovf=1, val=0.
   - signed a=0x80, b=0x10 → val=0x80, ovf=0.
   - signed a=0x80, b=0xF0 → ovf=1.
   - signed a=0x7F, b=0x10 → 0x7F.
4. Divide by zero: b=0x00, any a and mode → dbz=1, ovf=0, val=0, out_valid 1 cycle after accept. The next operation is computed normally.
5. Handshake and backpressure:
   - hold out_ready=0 for 5 cycles → val, flags and tag_out stable, in_ready=0, new in_valid ignored;
   - then out_ready=1 → one transfer, in_ready=1 on the next cycle;
   - back-to-back tags 0x3, 0x5 emerge in order.
6. Reset mid-operation: pull rst_n low during CALC, asynchronously (mid-cycle) → all outputs 0 immediately, state IDLE. No stale out_valid appears later, and the next operation gives the correct result.
